// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and constants for the 4x4 keypad scanner.
//   kp_state_e    - debounce FSM states
//   frame_class_e - classification of one complete 4-row scan frame
//   KEY_W, ROW_W  - key code and row drive widths
//   ROW_PATTERN   - active-low row drive word for each row index
package keypad_pkg;

  localparam int unsigned KEY_W = 4;
  localparam int unsigned ROW_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    DEB_PRESS,
    HELD,
    DEB_RELEASE
  } kp_state_e;

  typedef enum logic [1:0] {
    NONE,
    SINGLE,
    MULTI
  } frame_class_e;

  localparam logic [ROW_W-1:0] ROW_PATTERN [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

endpackage

// File: rtl/keypad_debounce.sv
// keypad_debounce: frame-rate press/release debouncer for the keypad scanner.
// Optional build macro: KEYPAD_REPEAT_EN (auto-repeat of key_valid while held).
// Ports:
//   clk, rst       - clock, synchronous active-high reset
//   frame_end_i    - one-clk strobe at the end of each scan frame
//   frame_class_i  - NONE / SINGLE / MULTI for the frame just completed
//   frame_code_i   - code of the first pressed key in that frame
//   key_code_o     - last accepted key code (held across release)
//   key_valid_o    - one-clk pulse per accepted press (and per repeat)
//   key_held_o     - debounced key-down indicator
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CNT = 4,
  parameter int unsigned REPEAT_DELAY = 40,
  parameter int unsigned REPEAT_RATE  = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_end_i,
  input  frame_class_e     frame_class_i,
  input  logic [KEY_W-1:0] frame_code_i,
  output logic [KEY_W-1:0] key_code_o,
  output logic             key_valid_o,
  output logic             key_held_o
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CNT + 1);

  kp_state_e        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d, cnt_inc;
  logic [KEY_W-1:0] cand_q, cand_d;
  logic [KEY_W-1:0] key_code_q, key_code_d;
  logic             key_valid_q, key_valid_d;
  logic             key_held_q, key_held_d;

  logic cnt_done;
  logic same_key;
  logic accept;
  logic release_done;
  logic rep_fire;

  assign cnt_inc      = cnt_q + 1'b1;
  assign cnt_done     = (cnt_inc == CW'(DEBOUNCE_CNT));
  assign same_key     = (frame_class_i == SINGLE) && (frame_code_i == cand_q);
  assign accept       = frame_end_i && (state_q == DEB_PRESS) && same_key && cnt_done;
  assign release_done = frame_end_i && (state_q == DEB_RELEASE) &&
                        (frame_class_i == NONE) && cnt_done;

`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RW   = $clog2(RMAX + 1);

  logic [RW-1:0] rep_cnt_q, rep_cnt_d, rep_nxt;
  logic          rep_first_q, rep_first_d;
  logic          held_enter;
  logic          held_stay;

  assign held_enter = accept ||
                      (frame_end_i && (state_q == DEB_RELEASE) && (frame_class_i != NONE));
  assign held_stay  = frame_end_i && (state_q == HELD) && (frame_class_i != NONE);
  assign rep_nxt    = rep_cnt_q + 1'b1;
  // First repeat waits REPEAT_DELAY frames, later ones REPEAT_RATE; counter restarts on each fire.
  assign rep_fire   = held_stay &&
                      (rep_nxt == (rep_first_q ? RW'(REPEAT_DELAY) : RW'(REPEAT_RATE)));

  always_comb begin
    rep_cnt_d   = rep_cnt_q;
    rep_first_d = rep_first_q;
    if (held_enter) begin
      rep_cnt_d   = '0;
      rep_first_d = 1'b1;
    end else if (rep_fire) begin
      rep_cnt_d   = '0;
      rep_first_d = 1'b0;
    end else if (held_stay) begin
      rep_cnt_d   = rep_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rep_cnt_q   <= '0;
      rep_first_q <= 1'b1;
    end else begin
      rep_cnt_q   <= rep_cnt_d;
      rep_first_q <= rep_first_d;
    end
  end
`else
  logic rep_cfg_unused;
  assign rep_cfg_unused = (REPEAT_DELAY != 0) ^ (REPEAT_RATE != 0);
  assign rep_fire       = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cand_q      <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cand_q      <= cand_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  // Next-state logic, evaluated only at frame end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    if (frame_end_i) begin
      case (state_q)
        IDLE: begin
          if (frame_class_i == SINGLE) begin
            cand_d  = frame_code_i;
            cnt_d   = CW'(1);
            state_d = DEB_PRESS;
          end
        end
        DEB_PRESS: begin
          if (same_key) begin
            if (cnt_done) begin
              cnt_d   = '0;
              state_d = HELD;
            end else begin
              cnt_d   = cnt_inc;
            end
          end else begin
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
        HELD: begin
          if (frame_class_i == NONE) begin
            cnt_d   = CW'(1);
            state_d = DEB_RELEASE;
          end
        end
        DEB_RELEASE: begin
          if (frame_class_i == NONE) begin
            if (cnt_done) begin
              cnt_d   = '0;
              state_d = IDLE;
            end else begin
              cnt_d   = cnt_inc;
            end
          end else begin
            cnt_d   = '0;
            state_d = HELD;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Output logic
  always_comb begin
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    if (accept) begin
      key_code_d  = cand_q;
      key_valid_d = 1'b1;
      key_held_d  = 1'b1;
    end
    if (rep_fire) begin
      key_valid_d = 1'b1;
    end
    if (release_done) begin
      key_held_d  = 1'b0;
    end
  end

  assign key_code_o  = key_code_q;
  assign key_valid_o = key_valid_q;
  assign key_held_o  = key_held_q;

endmodule

// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 key matrix scanner with synchronizer and frame debounce.
// Optional build macro: KEYPAD_REPEAT_EN (auto-repeat, see keypad_debounce).
// Ports:
//   clk       - system clock
//   rst       - synchronous reset, active-high
//   col       - matrix columns, active-low, asynchronous
//   row       - active-low one-hot row drive
//   key_code  - last accepted key, row*4+col
//   key_valid - one-clk pulse when key_code is updated
//   key_held  - high while the debounced key is down
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int unsigned CLK_DIV      = 1200,
  parameter int unsigned DEBOUNCE_CNT = 4,
  parameter int unsigned REPEAT_DELAY = 40,
  parameter int unsigned REPEAT_RATE  = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       col,
  output logic [ROW_W-1:0] row,
  output logic [KEY_W-1:0] key_code,
  output logic             key_valid,
  output logic             key_held
);

  localparam int unsigned DW = $clog2(CLK_DIV);

  logic [DW-1:0]    div_q, div_d;
  logic [1:0]       r_q, r_d;
  logic [3:0]       col_s1_q, col_s2_q;
  logic [1:0]       acc_cnt_q, acc_cnt_d;
  logic [KEY_W-1:0] acc_code_q, acc_code_d;

  logic             tick;
  logic [3:0]       pressed;
  logic [1:0]       row_cnt;
  logic [1:0]       col_idx;
  logic [2:0]       sum;
  logic [1:0]       tot;
  logic             frame_end;
  frame_class_e     frame_class;
  logic [KEY_W-1:0] frame_code;

  // Prescaler and row index
  always_comb begin
    tick  = (div_q == DW'(CLK_DIV - 1));
    div_d = tick ? '0 : div_q + 1'b1;
    r_d   = tick ? r_q + 2'd1 : r_q;
  end

  assign row = ROW_PATTERN[r_q];

  // Per-row contribution and running frame accumulation; the row-3 tick closes the frame
  // using the accumulated state plus that row's own contribution.
  always_comb begin
    pressed = ~col_s2_q;
    row_cnt = '0;
    col_idx = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (pressed[i] && (row_cnt != 2'd2)) begin
        row_cnt = row_cnt + 2'd1;
      end
    end
    for (int unsigned i = 4; i > 0; i--) begin
      if (pressed[i-1]) begin
        col_idx = 2'(i - 1);
      end
    end
    sum        = {1'b0, acc_cnt_q} + {1'b0, row_cnt};
    tot        = (sum >= 3'd2) ? 2'd2 : sum[1:0];
    frame_code = ((acc_cnt_q == 2'd0) && (|pressed)) ? {r_q, col_idx} : acc_code_q;
    frame_end  = tick && (r_q == 2'd3);
    case (tot)
      2'd0:    frame_class = NONE;
      2'd1:    frame_class = SINGLE;
      default: frame_class = MULTI;
    endcase
    acc_cnt_d  = acc_cnt_q;
    acc_code_d = acc_code_q;
    if (tick) begin
      if (frame_end) begin
        acc_cnt_d  = '0;
        acc_code_d = '0;
      end else begin
        acc_cnt_d  = tot;
        acc_code_d = frame_code;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q      <= '0;
      r_q        <= '0;
      col_s1_q   <= '1;
      col_s2_q   <= '1;
      acc_cnt_q  <= '0;
      acc_code_q <= '0;
    end else begin
      div_q      <= div_d;
      r_q        <= r_d;
      col_s1_q   <= col;
      col_s2_q   <= col_s1_q;
      acc_cnt_q  <= acc_cnt_d;
      acc_code_q <= acc_code_d;
    end
  end

  keypad_debounce #(
    .DEBOUNCE_CNT (DEBOUNCE_CNT),
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_RATE  (REPEAT_RATE)
  ) u_debounce (
    .clk           (clk),
    .rst           (rst),
    .frame_end_i   (frame_end),
    .frame_class_i (frame_class),
    .frame_code_i  (frame_code),
    .key_code_o    (key_code),
    .key_valid_o   (key_valid),
    .key_held_o    (key_held)
  );

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: scoreboard bench for keypad_scan (CLK_DIV=4, DEBOUNCE_CNT=3).
// Repeat scenario is included when KEYPAD_REPEAT_EN is defined.
module tb_keypad_scan;

  localparam int FRAME = 16;  // 4 rows x CLK_DIV

  localparam logic [15:0] K0  = 16'h0001;
  localparam logic [15:0] K3  = 16'h0008;
  localparam logic [15:0] K6  = 16'h0040;
  localparam logic [15:0] K9  = 16'h0200;
  localparam logic [15:0] K15 = 16'h8000;

  typedef struct {
    int code;
    int cyc;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [3:0]  col;
  logic [3:0]  row;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] keys;

  int   cyc;
  int   n_cmp;
  int   n_err;
  exp_t sb[$];
  exp_t e;
  logic [3:0] rot [4];

  keypad_scan #(
    .CLK_DIV      (4),
    .DEBOUNCE_CNT (3),
    .REPEAT_DELAY (5),
    .REPEAT_RATE  (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .col       (col),
    .row       (row),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  always #5 clk = ~clk;

  // Passive key matrix: a held key pulls its column low while its row is driven.
  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (!row[r] && keys[r*4+c]) col[c] = 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && key_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_key_valid", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("key_code_at_valid", {28'd0, key_code}, e.code);
        check("key_valid_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic push(input int code, input int frames_ahead);
    exp_t x;
    x.code = code;
    x.cyc  = cyc + frames_ahead * FRAME;
    sb.push_back(x);
  endtask

  task automatic reset_dut();
    rst  = 1'b1;
    keys = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic hold(input logic [15:0] k, input int n);
    keys = k;
    repeat (FRAME * n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_row"}, row, 4'b1110);
    check({pfx, "_key_code"}, key_code, 4'd0);
    check({pfx, "_key_valid"}, key_valid, 1'b0);
    check({pfx, "_key_held"}, key_held, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    clk   = 1'b0;
    rst   = 1'b1;
    keys  = '0;
    n_cmp = 0;
    n_err = 0;
    rot   = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    // Reset / idle and row rotation
    reset_dut();
    check_reset_outputs("reset");
    for (int i = 0; i < 8; i++) begin
      check("row_rotate", row, rot[i % 4]);
      repeat (4) @(posedge clk);
      #1;
    end

    // Clean press of key 6, then release boundary
    push(6, 3);
    hold(K6, 6);
    check("press_held", key_held, 1'b1);
    check("press_code", key_code, 4'd6);
    hold('0, 2);
    check("release_2_frames_held", key_held, 1'b1);
    hold('0, 1);
    check("release_3_frames_held", key_held, 1'b0);
    check("code_kept_after_release", key_code, 4'd6);

    // Bounce: no pulse, then a clean press shows FSM restarted from IDLE
    hold(K6, 1);
    hold('0, 1);
    hold(K6, 1);
    hold('0, 1);
    check("bounce_held", key_held, 1'b0);
    push(6, 3);
    hold(K6, 3);
    hold('0, 3);
    check("bounce_recover_held", key_held, 1'b0);

    // Multi-key blocked, single remaining key accepted
    hold(K0 | K15, 8);
    check("multi_held", key_held, 1'b0);
    push(0, 3);
    hold(K0, 4);
    check("multi_then_single_code", key_code, 4'd0);
    check("multi_then_single_held", key_held, 1'b1);
    hold('0, 3);
    check("multi_release_held", key_held, 1'b0);

    // Rollover blocked and release glitch
    push(6, 3);
    hold(K6, 4);
    hold(K9, 3);
    check("rollover_code", key_code, 4'd6);
    check("rollover_held", key_held, 1'b1);
    hold('0, 1);
    hold(K9, 3);
    check("glitch_code", key_code, 4'd6);
    check("glitch_held", key_held, 1'b1);
    hold('0, 3);
    check("glitch_release_held", key_held, 1'b0);

    // Reset during debounce (DEB_PRESS, cnt=2)
    hold(K6, 2);
    repeat (6) @(posedge clk);
    #1;
    reset_dut();
    check_reset_outputs("mid_rst");
    hold('0, 4);
    check("mid_rst_after_held", key_held, 1'b0);

`ifdef KEYPAD_REPEAT_EN
    // Auto-repeat: acceptance, +5, +7, +9 frames
    reset_dut();
    push(3, 3);
    push(3, 8);
    push(3, 10);
    push(3, 12);
    hold(K3, 12);
    check("repeat_code", key_code, 4'd3);
    hold('0, 3);
    check("repeat_release_held", key_held, 1'b0);
`endif

    repeat (20) @(posedge clk);
    #1;
    check("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
